// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM state type and width-derived constants for the arithmetic datapath
package arith_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] smin_of(input int w);
    logic [MAX_W-1:0] one;
    one = 1;
    return one << (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] umax_of(input int w);
    logic [MAX_W-1:0] ones;
    ones = '1;
    return ones >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, subtract divisor if it fits
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   prem_i,
  input  logic         bit_i,
  input  logic [N-1:0] dvs_i,
  output logic [N:0]   prem_o,
  output logic         q_o
);

  logic [N+1:0] shifted;

  always_comb begin
    shifted = {prem_i, bit_i};
    q_o     = (shifted >= {2'b00, dvs_i});
    prem_o  = q_o ? (shifted[N:0] - {1'b0, dvs_i}) : shifted[N:0];
  end

endmodule

// File: rtl/signed_or_unsigned_div_seq.sv
// rtl/signed_or_unsigned_div_seq.sv - sequential radix-2 restoring divider, signed or unsigned per transaction
module signed_or_unsigned_div_seq #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         down_vld,
  input  logic         down_rdy,
  output logic [n-1:0] quo,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);
  import arith_pkg::*;

  localparam logic [n-1:0] SMIN = n'(smin_of(n));
  localparam logic [n-1:0] UMAX = n'(umax_of(n));
  localparam int           CW   = $clog2(n);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  a_q, a_d, b_q, b_d;
  logic          sgn_q, sgn_d;
  logic [n-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
  logic [n:0]    prem_q, prem_d;
  logic [n-1:0]  quo_q, quo_d, rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [n:0]    step_prem;
  logic          step_q;
  logic          a_neg, b_neg;

  div_step #(.N(n)) u_step (
    .prem_i (prem_q),
    .bit_i  (dvd_q[n-1]),
    .dvs_i  (dvs_q),
    .prem_o (step_prem),
    .q_o    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    a_neg   = sgn_q & a_q[n-1];
    b_neg   = sgn_q & b_q[n-1];

    case (state_q)
      IDLE: begin
        if (up_vld) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_div;
          // |smin| = 2^(n-1) still fits as an unsigned n-bit magnitude
          dvd_d   = (signed_div && a[n-1]) ? -a : a;
          dvs_d   = (signed_div && b[n-1]) ? -b : b;
          prem_d  = '0;
          cnt_d   = CW'(n - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        prem_d = step_prem;
        dvd_d  = {dvd_q[n-2:0], step_q};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        if (b_q == '0) begin
          quo_d = UMAX;
          rem_d = a_q;
          dbz_d = 1'b1;
        end else if (sgn_q && a_q == SMIN && b_q == UMAX) begin
          quo_d = SMIN;
          rem_d = '0;
          dbz_d = 1'b0;
        end else begin
          quo_d = (a_neg ^ b_neg) ? -dvd_q : dvd_q;
          rem_d = a_neg ? -prem_q[n-1:0] : prem_q[n-1:0];
          dbz_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (down_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign up_rdy      = (state_q == IDLE);
  assign down_vld    = (state_q == DONE);
  assign quo         = quo_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_or_unsigned_div_seq.sv
// tb/tb_signed_or_unsigned_div_seq.sv - self-checking bench for the 4-bit sequential divider
module tb_signed_or_unsigned_div_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_vld;
  logic       up_rdy;
  logic [3:0] a, b;
  logic       signed_div;
  logic       down_vld;
  logic       down_rdy;
  logic [3:0] quo, rem;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  signed_or_unsigned_div_seq #(.n(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .up_vld      (up_vld),
    .up_rdy      (up_rdy),
    .a           (a),
    .b           (b),
    .signed_div  (signed_div),
    .down_vld    (down_vld),
    .down_rdy    (down_rdy),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {div_by_zero, quo, rem} from plain integer division
  function automatic logic [8:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic ms);
    int ai, bi, q, r;
    if (mb == 4'd0) return {1'b1, 4'hF, ma};
    ai = ms ? int'($signed(ma)) : int'(ma);
    bi = ms ? int'($signed(mb)) : int'(mb);
    if (ms && ai == -8 && bi == -1) return {1'b0, 4'h8, 4'h0};
    q = ai / bi;
    r = ai % bi;
    return {1'b0, 4'(q), 4'(r)};
  endfunction

  task automatic txn(input logic [3:0] ta, input logic [3:0] tb, input logic ts, input int hold);
    logic [8:0] exp;
    int cyc;
    string id;
    exp = model(ta, tb, ts);
    id  = $sformatf("a=%0h b=%0h s=%0b", ta, tb, ts);
    @(negedge clk);
    a = ta; b = tb; signed_div = ts; up_vld = 1'b1;
    chk({"up_rdy_idle ", id}, 32'(up_rdy), 32'd1);
    @(negedge clk);
    up_vld = 1'b0;
    chk({"up_rdy_busy ", id}, 32'(up_rdy), 32'd0);
    cyc = 0;
    while (!down_vld && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({"latency ", id}, 32'(cyc), 32'd5);
    chk({"result ", id}, 32'({div_by_zero, quo, rem}), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      a = ~ta; b = 4'd1; signed_div = ~ts; up_vld = 1'b1;
      @(negedge clk);
      chk({"hold_vld ", id}, 32'(down_vld), 32'd1);
      chk({"hold_rdy ", id}, 32'(up_rdy), 32'd0);
      chk({"hold_result ", id}, 32'({div_by_zero, quo, rem}), 32'(exp));
    end
    up_vld = 1'b0;
    down_rdy = 1'b1;
    @(negedge clk);
    down_rdy = 1'b0;
    chk({"release_vld ", id}, 32'(down_vld), 32'd0);
    chk({"release_rdy ", id}, 32'(up_rdy), 32'd1);
  endtask

  initial begin
    rst = 1'b1; up_vld = 1'b0; a = '0; b = '0; signed_div = 1'b0; down_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_up_rdy", 32'(up_rdy), 32'd1);
    chk("reset_down_vld", 32'(down_vld), 32'd0);
    chk("reset_outputs", 32'({div_by_zero, quo, rem}), 32'd0);
    rst = 1'b0;

    // Directed cases with hand-computed expectations
    txn(4'd13, 4'd3, 1'b0, 0);
    chk("u13_3", 32'({div_by_zero, quo, rem}), 32'({1'b0, 4'd4, 4'd1}));
    txn(4'b1001, 4'd2, 1'b1, 0);
    chk("s-7_2", 32'({div_by_zero, quo, rem}), 32'({1'b0, 4'b1101, 4'b1111}));
    txn(4'd7, 4'b1110, 1'b1, 0);
    chk("s7_-2", 32'({div_by_zero, quo, rem}), 32'({1'b0, 4'b1101, 4'd1}));
    txn(4'b1000, 4'b1111, 1'b1, 0);
    chk("s_ovf", 32'({div_by_zero, quo, rem}), 32'({1'b0, 4'b1000, 4'd0}));
    txn(4'd5, 4'd0, 1'b0, 0);
    chk("u_dbz", 32'({div_by_zero, quo, rem}), 32'({1'b1, 4'hF, 4'd5}));
    txn(4'd5, 4'd0, 1'b1, 0);
    chk("s_dbz", 32'({div_by_zero, quo, rem}), 32'({1'b1, 4'hF, 4'd5}));

    // Backpressure with ignored up_vld while DONE
    txn(4'd11, 4'd4, 1'b0, 3);

    // Reset two cycles after accept aborts the transaction
    @(negedge clk);
    a = 4'd13; b = 4'd3; signed_div = 1'b0; up_vld = 1'b1;
    @(negedge clk);
    up_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_down_vld", 32'(down_vld), 32'd0);
    chk("abort_up_rdy", 32'(up_rdy), 32'd1);
    chk("abort_outputs", 32'({div_by_zero, quo, rem}), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(down_vld), 32'd0);
    end

    // Exhaustive sweep, random backpressure on a subset
    for (int s = 0; s < 2; s++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          txn(4'(ia), 4'(ib), 1'(s), ($urandom % 8 == 0) ? int'($urandom_range(1, 2)) : 0);

    // Random operands
    for (int i = 0; i < 40; i++)
      txn(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
